lsu_mem: RTL and testbench
==========================

LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8, only 32 is supported.
REQ-002 Parameter ADDR_W, default 10, byte-address width; storage depth is 2**ADDR_W bytes.
REQ-003 Parameter LATENCY, default 1, wait cycles per access; legal range 1..15.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  requester has a valid request.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 req_signed  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  DATA_W  store data, right-aligned (byte uses [7:0], half uses [15:0]).
REQ-013 resp_valid  out  1  one-cycle response pulse.
REQ-014 resp_rdata  out  DATA_W  load result; 0 for stores and errors.
REQ-015 resp_err  out  1  misaligned or illegal-size request; valid only with resp_valid.

Function
REQ-016 FSM states SHALL be IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 in IDLE only; a request is accepted on a posedge where req_valid && req_ready.
REQ-018 All request fields SHALL be captured at acceptance; later changes to the inputs SHALL NOT affect that access.
REQ-019 Legal accepted request (edge E0): IDLE->WAIT, and a down-counter SHALL load LATENCY.
REQ-020 In WAIT the counter SHALL decrement each edge; at edge E0+LATENCY the access SHALL commit and the FSM SHALL enter RESP.
REQ-021 Commit means stores write the memory array and loads latch resp_rdata.
REQ-022 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; total occupancy is LATENCY+2 cycles per request.
REQ-023 Byte order SHALL be big-endian: word at A stores [31:24] at A, [23:16] at A+1, [15:8] at A+2, [7:0] at A+3; half at A stores [15:8] at A, [7:0] at A+1.
REQ-024 Stores SHALL modify only the 1, 2 or 4 addressed bytes.
REQ-025 Byte and half loads SHALL be extended to DATA_W per req_signed.
REQ-026 A request is misaligned when it is half with A[0]=1, or word with A[1:0]!=0.
REQ-027 A misaligned or size-11 request SHALL go IDLE->RESP at E0 with resp_err=1, resp_rdata=0 and no memory write.
REQ-028 Byte addresses SHALL wrap modulo 2**ADDR_W; aligned accesses never cross the top boundary.
REQ-029 resp_err and resp_rdata SHALL be 0 whenever resp_valid=0.

Reset
REQ-030 reset SHALL force IDLE, counter=0, req_ready=1 after the edge, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-031 reset during WAIT SHALL abort the access: no memory write and no response.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 reset SHALL take priority over request acceptance on the same edge.

Structure
REQ-034 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the alignment-check function.
REQ-035 Byte storage SHALL be a sub-module lsu_byte_ram with one read port (4 consecutive bytes) and a write port with 4 byte-enables, written on posedge clk.

Verification (LATENCY=2 unless stated)
REQ-036 Store word 0xDEADBEEF at 0x010, then load word at 0x010 -> first resp_valid 3 edges after acceptance, resp_err=0; then resp_rdata=0xDEADBEEF.
REQ-037 After REQ-036, load byte at 0x011 signed -> 0xFFFFFFAD; unsigned -> 0x000000AD; load half at 0x012 signed -> 0xFFFFBEEF.
REQ-038 Store byte 0x12 (wdata 0xAAAAAA12) at 0x013, then load word at 0x010 -> 0xDEADBE12 (other bytes untouched).
REQ-039 Load word at 0x006, load half at 0x003, and a size-11 request -> each has resp_valid one edge after acceptance, resp_err=1, resp_rdata=0; memory at 0x004..0x007 unchanged.
REQ-040 Assert reset one cycle into WAIT of a store of 0x11223344 at 0x020 -> no resp_valid, req_ready=1 after the reset edge; a later load at 0x020 returns the prior contents.
REQ-041 LATENCY=1 with req_valid held high for 3 requests -> acceptances 3 cycles apart, req_ready=0 in WAIT and RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory block: access sizes, FSM states
// and the alignment/legality check applied at request acceptance.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // 1 when the request must be rejected: illegal size or misaligned address.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] a_lo);
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = a_lo[0];
      SZ_WORD: access_err = |a_lo;
      default: access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_ram.sv
// Byte-addressed storage: one 4-byte read window starting at raddr_i and a
// 4-lane byte-enabled write port; lane l always targets address + l (wrapping).
module lsu_byte_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [3:0][7:0]   rbytes_o,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [3:0]        we_i,
  input  logic [3:0][7:0]   wbytes_i
);

  localparam int DEPTH = 2**ADDR_W;

  logic [7:0] mem_q [DEPTH];

  for (genvar l = 0; l < 4; l++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra          = raddr_i + ADDR_W'(l);
    assign rbytes_o[l] = mem_q[ra];
  end

  // No reset: contents survive a block reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we_i[l]) mem_q[waddr_i + ADDR_W'(l)] <= wbytes_i[l];
    end
  end

endmodule

// File: rtl/lsu_mem.sv
// Single-outstanding load/store unit in front of a big-endian byte RAM.
// Legal requests wait LATENCY cycles then commit; bad ones respond at once.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                wr_q, sgn_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                accept, commit;
  logic [3:0][7:0]     rb, wbytes;
  logic [3:0]          wmask, we;
  logic [DATA_W-1:0]   ld_data;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign accept = req_valid && req_ready;
  assign commit = (state_q == WAIT) && (cnt_q <= 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (access_err(req_size, req_addr[1:0])) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (commit) begin
          state_d = RESP;
          if (!wr_q) rdata_d = ld_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are frozen at acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      sgn_q   <= req_signed;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Big-endian: lane 0 is the lowest address and holds the most significant byte.
  always_comb begin
    case (size_q)
      SZ_BYTE: ld_data = {{(DATA_W-8){sgn_q & rb[0][7]}}, rb[0]};
      SZ_HALF: ld_data = {{(DATA_W-16){sgn_q & rb[0][7]}}, rb[0], rb[1]};
      default: ld_data = {rb[0], rb[1], rb[2], rb[3]};
    endcase
  end

  always_comb begin
    wbytes = '0;
    wmask  = '0;
    case (size_q)
      SZ_BYTE: begin
        wbytes[0] = wdata_q[7:0];
        wmask     = 4'b0001;
      end
      SZ_HALF: begin
        wbytes[0] = wdata_q[15:8];
        wbytes[1] = wdata_q[7:0];
        wmask     = 4'b0011;
      end
      default: begin
        wbytes = {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};
        wmask  = 4'b1111;
      end
    endcase
  end

  // Reset on the commit edge aborts the store.
  assign we = (commit && wr_q && !reset) ? wmask : 4'b0000;

  lsu_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk      (clk),
    .raddr_i  (addr_q),
    .rbytes_o (rb),
    .waddr_i  (addr_q),
    .we_i     (we),
    .wbytes_i (wbytes)
  );

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: table of requests scored through an expectation queue,
// plus hand sequences for reset-in-WAIT, reset priority and back-to-back issue.
module tb_lsu_mem;
  import lsu_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        r1_valid = 1'b0, r1_write = 1'b0, r1_signed = 1'b0;
  logic [1:0]  r1_size = 2'b00;
  logic [9:0]  r1_addr = '0;
  logic [31:0] r1_wdata = '0;
  logic        r1_ready, r1_resp_valid, r1_resp_err;
  logic [31:0] r1_resp_rdata;

  always #5 clk = ~clk;

  lsu_mem #(.DATA_W(32), .ADDR_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err));

  lsu_mem #(.DATA_W(32), .ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(r1_valid), .req_ready(r1_ready),
    .req_write(r1_write), .req_size(r1_size), .req_signed(r1_signed),
    .req_addr(r1_addr), .req_wdata(r1_wdata), .resp_valid(r1_resp_valid),
    .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err));

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   r1_resp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every response pops one expectation; idle outputs must be zero.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("resp_without_req", {31'b0, resp_valid}, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        end
      end else begin
        chk("idle_rdata", resp_rdata, 32'd0);
        chk("idle_err", {31'b0, resp_err}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && r1_resp_valid === 1'b1) begin
      r1_resp_cnt++;
      chk("l1_resp_rdata", r1_resp_rdata, 32'd0);
      chk("l1_resp_ready", {31'b0, r1_ready}, 32'd0);
    end
  end

  // Called at a negedge; returns at a negedge with the DUT idle again.
  task automatic do_req(input vec_t v);
    int n, lat;
    exp_q.push_back('{v.exp_rdata, v.exp_err});
    req_valid = 1'b1; req_write = v.wr; req_size = v.size;
    req_signed = v.sgn; req_addr = v.addr; req_wdata = v.wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = 10'($urandom); req_wdata = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk("resp_latency", 32'(lat), 32'(v.exp_lat));
    @(negedge clk);
  endtask

  vec_t tv[$];

  initial begin
    int acc, last;
    logic [31:0] e = 32'h0;

    tv.push_back('{1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_BYTE, 1'b1, 10'h011, 32'h0,        32'hFFFFFFAD, 1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_BYTE, 1'b0, 10'h011, 32'h0,        32'h000000AD, 1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_HALF, 1'b1, 10'h012, 32'h0,        32'hFFFFBEEF, 1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_HALF, 1'b0, 10'h010, 32'h0,        32'h0000DEAD, 1'b0, LAT+1});
    tv.push_back('{1'b1, SZ_BYTE, 1'b0, 10'h013, 32'hAAAAAA12, 32'h0,        1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0,        32'hDEADBE12, 1'b0, LAT+1});
    tv.push_back('{1'b1, SZ_WORD, 1'b0, 10'h004, 32'h01020304, 32'h0,        1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_WORD, 1'b0, 10'h006, 32'h0,        32'h0,        1'b1, 1});
    tv.push_back('{1'b0, SZ_HALF, 1'b0, 10'h003, 32'h0,        32'h0,        1'b1, 1});
    tv.push_back('{1'b0, 2'b11,   1'b0, 10'h004, 32'h0,        32'h0,        1'b1, 1});
    tv.push_back('{1'b1, SZ_WORD, 1'b0, 10'h005, 32'hFFFFFFFF, 32'h0,        1'b1, 1});
    tv.push_back('{1'b1, 2'b11,   1'b0, 10'h004, 32'hFFFFFFFF, 32'h0,        1'b1, 1});
    tv.push_back('{1'b1, SZ_HALF, 1'b0, 10'h005, 32'hFFFFFFFF, 32'h0,        1'b1, 1});
    tv.push_back('{1'b0, SZ_WORD, 1'b0, 10'h004, 32'h0,        32'h01020304, 1'b0, LAT+1});
    tv.push_back('{1'b1, SZ_WORD, 1'b0, 10'h3FC, 32'h11223344, 32'h0,        1'b0, LAT+1});
    tv.push_back('{1'b1, SZ_HALF, 1'b0, 10'h3FE, 32'h0000CAFE, 32'h0,        1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_WORD, 1'b0, 10'h3FC, 32'h0,        32'h1122CAFE, 1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_BYTE, 1'b0, 10'h3FF, 32'h0,        32'h000000FE, 1'b0, LAT+1});
    tv.push_back('{1'b0, SZ_HALF, 1'b1, 10'h3FE, 32'h0,        32'hFFFFCAFE, 1'b0, LAT+1});
    tv.push_back('{1'b1, SZ_WORD, 1'b0, 10'h020, 32'h55667788, 32'h0,        1'b0, LAT+1});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < tv.size(); i++) do_req(tv[i]);

    // Reset one cycle into WAIT: store must be dropped, no response.
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD;
    req_addr = 10'h020; req_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    repeat (4) @(negedge clk);

    // Reset and a legal request on the same edge: reset wins.
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD;
    req_addr = 10'h020; req_wdata = 32'h99999999;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    chk("prio_ready0", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    chk("prio_ready1", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    do_req('{1'b0, SZ_WORD, 1'b0, 10'h020, 32'h0, 32'h55667788, 1'b0, LAT+1});

    // LATENCY=1 with valid held high: acceptances every 3 cycles.
    r1_valid = 1'b1; r1_write = 1'b1; r1_size = SZ_WORD;
    r1_addr = 10'h040; r1_wdata = 32'h0BADF00D;
    acc = 0; last = -1;
    for (int c = 0; c < 30 && acc < 3; c++) begin
      if (r1_ready === 1'b1) begin
        if (last >= 0) chk("l1_accept_gap", 32'(c - last), 32'd3);
        last = c;
        acc++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    r1_valid = 1'b0;
    chk("l1_accept_cnt", 32'(acc), 32'd3);
    repeat (5) @(negedge clk);
    chk("l1_resp_cnt", 32'(r1_resp_cnt), 32'd3);

    chk("pending_exp", 32'(exp_q.size()), 32'(e));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
